// File: rtl/stream_pkg.sv
// Shared definitions for the stream buffering stages: default widths and
// helpers that size pointers and occupancy counters from a depth.
package stream_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

  // Per-cycle transfer combination seen by a FIFO; drives the pointer/count update.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : stream_pkg

// File: rtl/stream_fifo_mem.sv
// Storage array for stream_fifo: one synchronous write port and one
// asynchronous read port, no reset on the contents.
module stream_fifo_mem
  import stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : stream_fifo_mem

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO; full/empty come from the
// registered occupancy count. Define STREAM_FIFO_AF_EN to add almost_full.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_data,
`ifdef STREAM_FIFO_AF_EN
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    almost_full
`else
  output logic [cnt_w(DEPTH)-1:0] count
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("stream_fifo: AF_LEVEL must lie in 1..DEPTH");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("stream_fifo: DATA_W must be >= 1");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  fifo_op_e      op;
  logic [DATA_W-1:0] rd_data;

  // Flags are taken from registered count only, so s_ready never sees m_ready.
  assign s_ready = (count_q != CW'(DEPTH));
  assign m_valid = (count_q != '0);
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;
  assign op      = fifo_op_e'({pop, push});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (op)
      OP_PUSH: begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        count_d  = count_q + CW'(1);
      end
      OP_POP: begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        count_d  = count_q - CW'(1);
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  stream_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (s_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Storage is never reset, so the head is masked to zero while empty.
  assign m_data = m_valid ? rd_data : '0;
  assign count  = count_q;

`ifdef STREAM_FIFO_AF_EN
  logic almost_full_q, almost_full_d;

  always_comb begin
    almost_full_d = (count_d >= CW'(AF_LEVEL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule : stream_fifo

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo (DEPTH=8, DATA_W=8); almost_full
// checks are compiled in when STREAM_FIFO_AF_EN is defined.
module tb_stream_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CW-1:0]     count;
`ifdef STREAM_FIFO_AF_EN
  logic              almost_full;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic       s_valid;
    logic [7:0] s_data;
    logic       m_ready;
    logic       exp_s_ready;
    logic       exp_m_valid;
    logic [7:0] exp_m_data;
    int         exp_count;
  } vec_t;

  vec_t vecs[11];
  logic [7:0] popped[$];

  stream_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
`ifdef STREAM_FIFO_AF_EN
    .count       (count),
    .almost_full (almost_full)
`else
    .count       (count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, record any word popped at the edge, and
  // return 1 time unit after the rising edge.
  task automatic applyStimulus(input logic sv, input logic [7:0] sd, input logic mr);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    #3;
    if (m_valid && m_ready) popped.push_back(m_data);
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string name, input logic sr, input logic mv,
                            input logic [7:0] md, input int cnt);
    checkOutput({name, ".s_ready"}, 32'(s_ready), 32'(sr));
    checkOutput({name, ".m_valid"}, 32'(m_valid), 32'(mv));
    checkOutput({name, ".m_data"},  32'(m_data),  32'(md));
    checkOutput({name, ".count"},   32'(count),   32'(cnt));
  endtask

  task automatic doReset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    popped.delete();
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;

    // {s_valid, s_data, m_ready, exp s_ready, exp m_valid, exp m_data, exp count}
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1};
    vecs[2]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 2};
    vecs[3]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3};
    vecs[4]  = '{1'b0, 8'h99, 1'b0, 1'b1, 1'b1, 8'h11, 3};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 2};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
    vecs[8]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h44, 1};
    vecs[9]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};

    #2;
    checkState("reset_async", 1'b1, 1'b0, 8'h00, 0);
    doReset();
    checkState("reset_idle", 1'b1, 1'b0, 8'h00, 0);

    // Table: basic ordering, hold while stalled, empty push+pop boundary.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].s_valid, vecs[i].s_data, vecs[i].m_ready);
      checkState($sformatf("vec%0d", i), vecs[i].exp_s_ready, vecs[i].exp_m_valid,
                 vecs[i].exp_m_data, vecs[i].exp_count);
    end

    // Fill to full, then a refused ninth word, then drain in order.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
    end
    checkState("full", 1'b0, 1'b1, 8'hA0, 8);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkState("full_refuse", 1'b0, 1'b1, 8'hA0, 8);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("drain_len", 32'(popped.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < popped.size(); i++) begin
      checkOutput($sformatf("drain%0d", i), 32'(popped[i]), 32'(8'hA0 + 8'(i)));
    end
    checkState("drained", 1'b1, 1'b0, 8'h00, 0);

    // Full with simultaneous push/pop: pop only, then both together.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0);
    end
    applyStimulus(1'b1, 8'hFF, 1'b1);
    checkState("full_pop_only", 1'b1, 1'b1, 8'hB1, 7);
    applyStimulus(1'b1, 8'hB8, 1'b1);
    checkState("both_at7", 1'b1, 1'b1, 8'hB2, 7);
    popped.delete();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("both_drain_len", 32'(popped.size()), 32'd7);
    for (int i = 0; i < 7 && i < popped.size(); i++) begin
      checkOutput($sformatf("both_drain%0d", i), 32'(popped[i]), 32'(8'hB2 + 8'(i)));
    end

    // Wrap-around streaming at occupancy 3.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
    end
    for (int i = 3; i < 20; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1);
      if (i == 10) checkOutput("wrap_count", 32'(count), 32'd3);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("wrap_len", 32'(popped.size()), 32'd20);
    for (int i = 0; i < 20 && i < popped.size(); i++) begin
      checkOutput($sformatf("wrap%0d", i), 32'(popped[i]), 32'(i));
    end

    // Asynchronous reset in the middle of a burst.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0);
    end
    checkOutput("pre_rst_count", 32'(count), 32'd5);
    s_valid = 1'b1;
    m_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkState("mid_rst", 1'b1, 1'b0, 8'h00, 0);
    doReset();
    checkState("after_rst", 1'b1, 1'b0, 8'h00, 0);

`ifdef STREAM_FIFO_AF_EN
    checkOutput("af_reset", 32'(almost_full), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
    end
    checkOutput("af_at5", 32'(almost_full), 32'd0);
    applyStimulus(1'b1, 8'h05, 1'b0);
    checkOutput("af_at6", 32'(almost_full), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("af_back5", 32'(almost_full), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_stream_fifo

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Synchronous valid/ready FIFO that buffers a data stream between a producer and a consumer stage in the same clock domain.
- Decouples upstream burst timing from downstream back-pressure.
- It is the standard buffering stage placed directly in front of any sequential consumer block built on the team's module skeleton.
- Output is first-word-fall-through (FWFT): the head word is presented on m_data whenever m_valid is high.

Parameters:
- DATA_W, 8, width of each data word in bits (>=1).
- DEPTH, 8, number of storage entries; power of two, >=2.
- AF_LEVEL, 6, almost-full threshold in entries; used only when STREAM_FIFO_AF_EN is defined; 1 <= AF_LEVEL <= DEPTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  FIFO can accept a word this cycle.
- s_data  in  DATA_W  upstream word.
- m_valid  out  1  head word available.
- m_ready  in  1  downstream accepts head word.
- m_data  out  DATA_W  head word.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full  out  1  present only with STREAM_FIFO_AF_EN.

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - m_valid = 0, s_ready = 1.
  - m_data = 0; storage contents are don't-care.
- Handshake rules:
  - push = s_valid & s_ready; pop = m_valid & m_ready.
  - Transfers occur only on a rising edge with the handshake high.
- s_ready:
  - s_ready = (count != DEPTH).
  - It depends only on registered state, with no combinational path from m_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
- m_valid:
  - m_valid = (count != 0).
  - m_data = mem[rd_ptr] and is held stable while m_valid & ~m_ready.
- Latency: a word pushed into an empty FIFO at edge N appears with m_valid=1 after edge N (one-cycle latency); there is no same-cycle bypass.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Full/empty are decided by count, not by pointer comparison.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - neither: unchanged.
- Boundaries:
  - Empty with s_valid=1 and m_ready=1: only the push happens (m_valid was 0), so count goes 0 -> 1.
  - Full with m_ready=1: pop only, so count goes DEPTH -> DEPTH-1, and s_ready rises the next cycle.
  - A push while s_ready=0 is ignored; the upstream must hold s_valid/s_data (AXI-stream rules).
- Reset mid-operation: all contents are discarded immediately, outputs return to reset values asynchronously, and no partial transfer completes.
- There is no overflow or underflow state: the handshake makes both impossible.

Optional Feature:
- Macro: STREAM_FIFO_AF_EN.
- Defined:
  - Adds the almost_full output, registered.
  - almost_full = 1 when the next-cycle count >= AF_LEVEL, so it is aligned with count.
  - Reset value 0.
- Undefined: the almost_full port and its logic are absent; AF_LEVEL is unused.

Decomposition:
- Package stream_pkg:
  - function ptr_w(depth) returning $clog2(depth).
  - function cnt_w(depth) returning $clog2(depth+1).
  - localparam default DATA_W/DEPTH values shared with neighbouring stream stages.
- Sub-module stream_fifo_mem:
  - Simple dual-port register array: write port (we, waddr, wdata), asynchronous read (raddr -> rdata).
  - No reset on storage.
  - stream_fifo instantiates it and owns all pointer, count and handshake logic.

Test Plan:
- Reset, then idle, DEPTH=8: s_ready=1, m_valid=0, count=0; asserting rst mid-burst with count=5 gives count=0 and m_valid=0 in the same cycle.
- Push 0x11, 0x22, 0x33 with m_ready=0: count=3, m_data=0x11 stable; then m_ready=1 for 3 cycles outputs 0x11, 0x22, 0x33 in order, and count returns to 0.
- Fill 8 words 0xA0..0xA7: s_ready=0 at count=8; a 9th s_valid with 0xFF is not accepted; drain yields exactly 0xA0..0xA7.
- Full plus simultaneous s_valid=1/m_ready=1: pop only, count 8 -> 7; next cycle push and pop together keep count at 7.
- Wrap-around: 20 continuous push/pop cycles with data 0..19 and an occupancy of 3: output sequence is 0..19 in order with no gaps or duplicates.
- With STREAM_FIFO_AF_EN and AF_LEVEL=6: almost_full rises on the cycle count becomes 6 and falls when count drops to 5; built without the macro, the port is absent and the design elaborates cleanly.
